// File: rtl/key_event_pkg.sv
// Shared definitions for the push-button event controller: channel state
// encoding, millisecond-to-cycle conversion and parameter legality.
package key_event_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_PRESSED   = 2'd1;
  localparam state_t ST_LONG_HELD = 2'd2;

  function automatic int ms_to_cycles(input int clkFreq, input int ms);
    return clkFreq / 1000 * ms;
  endfunction

  function automatic bit params_legal(input int clkFreq, input int keyNum,
                                      input int debounceMs, input int longMs);
    return (debounceMs >= 1) &&
           (ms_to_cycles(clkFreq, longMs) > ms_to_cycles(clkFreq, debounceMs)) &&
           (keyNum >= 1) && (keyNum <= 16);
  endfunction

endpackage

// File: rtl/key_event_ch.sv
// One key channel: two-flop synchroniser, debounce and hold counters,
// press/long/release classification and the per-key toggle flag.
module key_event_ch
  import key_event_pkg::*;
#(
  parameter int DEB_CYC        = 4,
  parameter int LONG_CYC       = 10,
  parameter int CNT_W          = 4,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int TOGGLE_SRC     = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic level_o,
  output logic pressPulse_o,
  output logic releasePulse_o,
  output logic longPulse_o,
  output logic toggle_o
);

  localparam logic             IDLE_RAW  = (KEY_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             pressedNow;
  logic             accept;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] debCnt_q, debCnt_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             toggle_q, toggle_d;

  // Synchroniser resets to the released raw level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressedNow = sync2_q ^ IDLE_RAW;

  always_comb begin
    debCnt_d  = '0;
    accept    = 1'b0;
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    toggle_d  = toggle_q;

    if (pressedNow != level_q) begin
      if (debCnt_q == DEB_LAST) begin
        accept = 1'b1;
      end else begin
        debCnt_d = debCnt_q + CNT_W'(1);
      end
    end
    level_d = accept ? pressedNow : level_q;

    // An accepted release wins over a long press maturing in the same cycle.
    case (state_q)
      ST_IDLE: begin
        if (accept && pressedNow) begin
          state_d   = ST_PRESSED;
          holdCnt_d = '0;
          press_d   = 1'b1;
          if (TOGGLE_SRC == 0) toggle_d = ~toggle_q;
        end
      end
      ST_PRESSED: begin
        if (accept && !pressedNow) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          if (TOGGLE_SRC != 0) toggle_d = ~toggle_q;
        end else if (holdCnt_q == LONG_LAST) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end else begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (accept && !pressedNow) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      debCnt_q  <= '0;
      holdCnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      debCnt_q  <= debCnt_d;
      holdCnt_q <= holdCnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      toggle_q  <= toggle_d;
    end
  end

  assign level_o        = level_q;
  assign pressPulse_o   = press_q;
  assign releasePulse_o = release_q;
  assign longPulse_o    = long_q;
  assign toggle_o       = toggle_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key push-button event controller: one independent channel per key,
// outputs gathered onto per-key buses.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int CLK_FREQ       = 27_000_000,
  parameter int KEY_NUM        = 1,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 500,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int TOGGLE_SRC     = 0
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic [KEY_NUM-1:0] I_key,
  output logic [KEY_NUM-1:0] O_key_level,
  output logic [KEY_NUM-1:0] O_press_pulse,
  output logic [KEY_NUM-1:0] O_release_pulse,
  output logic [KEY_NUM-1:0] O_long_pulse,
  output logic [KEY_NUM-1:0] O_toggle
);

  localparam int DEB_CYC  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int CNT_W    = $clog2(LONG_CYC + 1);

  if (!params_legal(CLK_FREQ, KEY_NUM, DEBOUNCE_MS, LONG_MS)) begin : g_bad_params
    $error("key_event_ctrl: illegal KEY_NUM / DEBOUNCE_MS / LONG_MS combination");
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_event_ch #(
      .DEB_CYC       (DEB_CYC),
      .LONG_CYC      (LONG_CYC),
      .CNT_W         (CNT_W),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
      .TOGGLE_SRC    (TOGGLE_SRC)
    ) u_ch (
      .clk_i         (I_clk),
      .rst_ni        (I_rst_n),
      .key_i         (I_key[i]),
      .level_o       (O_key_level[i]),
      .pressPulse_o  (O_press_pulse[i]),
      .releasePulse_o(O_release_pulse[i]),
      .longPulse_o   (O_long_pulse[i]),
      .toggle_o      (O_toggle[i])
    );
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: three instances (press toggle, release
// toggle, active-high keys) driven with hand-timed key sequences.
module tb_key_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] keyA, keyC;
  logic [1:0] levA, prA, relA, lngA, togA;
  logic [1:0] levB, prB, relB, lngB, togB;
  logic [1:0] levC, prC, relC, lngC, togC;

  int compared   = 0;
  int mismatched = 0;
  int pressCnt0  = 0;
  int releaseCnt0 = 0;
  int longCnt0   = 0;

  int rawSeq [11] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
  int expCnt [11] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 0};

  always #5 clk = ~clk;

  key_event_ctrl #(.CLK_FREQ(1000), .KEY_NUM(2), .DEBOUNCE_MS(4), .LONG_MS(10),
                   .KEY_ACTIVE_LOW(1), .TOGGLE_SRC(0)) dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_key(keyA), .O_key_level(levA),
    .O_press_pulse(prA), .O_release_pulse(relA), .O_long_pulse(lngA), .O_toggle(togA));

  key_event_ctrl #(.CLK_FREQ(1000), .KEY_NUM(2), .DEBOUNCE_MS(4), .LONG_MS(10),
                   .KEY_ACTIVE_LOW(1), .TOGGLE_SRC(1)) dut_b (
    .I_clk(clk), .I_rst_n(rst_n), .I_key(keyA), .O_key_level(levB),
    .O_press_pulse(prB), .O_release_pulse(relB), .O_long_pulse(lngB), .O_toggle(togB));

  key_event_ctrl #(.CLK_FREQ(1000), .KEY_NUM(2), .DEBOUNCE_MS(4), .LONG_MS(10),
                   .KEY_ACTIVE_LOW(0), .TOGGLE_SRC(0)) dut_c (
    .I_clk(clk), .I_rst_n(rst_n), .I_key(keyC), .O_key_level(levC),
    .O_press_pulse(prC), .O_release_pulse(relC), .O_long_pulse(lngC), .O_toggle(togC));

  // Tally key0 pulses of the press-toggle instance to catch extra or missing events.
  always @(negedge clk) begin
    if (prA[0])  pressCnt0   <= pressCnt0 + 1;
    if (relA[0]) releaseCnt0 <= releaseCnt0 + 1;
    if (lngA[0]) longCnt0    <= longCnt0 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] c);
    keyA = a;
    keyC = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(2'b11, 2'b00);
    tick(2);
    checkOutput("rst_levelA",  levA, 0);
    checkOutput("rst_pressA",  prA, 0);
    checkOutput("rst_toggleB", togB, 0);
    checkOutput("rst_levelC",  levC, 0);
    checkOutput("rst_syncA",   dut_a.g_ch[0].u_ch.sync2_q, 1);
    checkOutput("rst_syncC",   dut_c.g_ch[0].u_ch.sync2_q, 0);
    rst_n = 1'b1;
    tick(3);

    // Clean press: driven after edge E, accepted at E+6, long at E+16.
    applyStimulus(2'b10, 2'b01);
    tick(5);
    checkOutput("cp_early_pressA", prA, 0);
    checkOutput("cp_early_levelA", levA, 0);
    checkOutput("cp_early_pressC", prC, 0);
    tick(1);
    checkOutput("cp_levelA",  levA, 2'b01);
    checkOutput("cp_pressA",  prA, 2'b01);
    checkOutput("cp_toggleA", togA, 2'b01);
    checkOutput("cp_toggleB", togB, 2'b00);
    checkOutput("cp_levelC",  levC, 2'b01);
    checkOutput("cp_pressC",  prC, 2'b01);
    checkOutput("cp_toggleC", togC, 2'b01);
    tick(1);
    checkOutput("cp_pulse_width", prA, 0);
    tick(8);
    checkOutput("cp_long_early", lngA, 0);
    tick(1);
    checkOutput("cp_longA", lngA, 2'b01);
    checkOutput("cp_longB", lngB, 2'b01);
    checkOutput("cp_longC", lngC, 2'b01);
    tick(1);
    checkOutput("cp_long_width", lngA, 0);
    tick(25);
    checkOutput("cp_hold_sat", dut_a.g_ch[0].u_ch.holdCnt_q, 9);
    applyStimulus(2'b11, 2'b00);
    tick(5);
    checkOutput("cp_rel_early", relA, 0);
    tick(1);
    checkOutput("cp_releaseA", relA, 2'b01);
    checkOutput("cp_releaseB", relB, 2'b01);
    checkOutput("cp_releaseC", relC, 2'b01);
    checkOutput("cp_rel_levelA", levA, 0);
    checkOutput("cp_rel_toggleA", togA, 2'b01);
    checkOutput("cp_long_rel_toggleB", togB, 2'b00);
    tick(1);
    checkOutput("cp_rel_width", relA, 0);

    // Short press: level held 6 cycles, released before the long threshold.
    tick(2);
    applyStimulus(2'b10, 2'b00);
    tick(6);
    checkOutput("sp_pressA",  prA, 2'b01);
    checkOutput("sp_toggleA", togA, 2'b00);
    applyStimulus(2'b11, 2'b00);
    tick(6);
    checkOutput("sp_releaseB", relB, 2'b01);
    checkOutput("sp_toggleB",  togB, 2'b01);
    checkOutput("sp_longA",    lngA, 0);

    // Bounce: two 3-cycle lows split by a 1-cycle high never reach acceptance.
    tick(2);
    for (int i = 0; i < 11; i++) begin
      keyA[0] = rawSeq[i][0];
      tick(1);
      checkOutput($sformatf("bn_cnt%0d", i), dut_a.g_ch[0].u_ch.debCnt_q, expCnt[i]);
      checkOutput($sformatf("bn_lvl%0d", i), levA, 0);
    end

    // Simultaneous press, key1 released first, key0 three cycles later.
    tick(2);
    applyStimulus(2'b00, 2'b00);
    tick(5);
    checkOutput("sim_early", prA, 0);
    tick(1);
    checkOutput("sim_pressA",  prA, 2'b11);
    checkOutput("sim_levelA",  levA, 2'b11);
    checkOutput("sim_toggleA", togA, 2'b11);
    applyStimulus(2'b10, 2'b00);
    tick(3);
    applyStimulus(2'b11, 2'b00);
    tick(3);
    checkOutput("sim_rel1",     relA, 2'b10);
    checkOutput("sim_rel1_lvl", levA, 2'b01);
    checkOutput("sim_rel1_togB", togB, 2'b11);
    tick(3);
    checkOutput("sim_rel0",     relA, 2'b01);
    checkOutput("sim_rel0_lvl", levA, 0);
    checkOutput("sim_rel0_togB", togB, 2'b10);

    // Reset while in the long-held state, key kept pressed throughout.
    tick(2);
    applyStimulus(2'b10, 2'b00);
    tick(6);
    checkOutput("rm_pressA", prA, 2'b01);
    tick(10);
    checkOutput("rm_longA", lngA, 2'b01);
    tick(3);
    rst_n = 1'b0;
    #1;
    checkOutput("rm_levelA",   levA, 0);
    checkOutput("rm_releaseA", relA, 0);
    checkOutput("rm_toggleA",  togA, 0);
    checkOutput("rm_toggleB",  togB, 0);
    checkOutput("rm_toggleC",  togC, 0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    checkOutput("rm_early", prA, 0);
    tick(1);
    checkOutput("rm_repress", prA, 2'b01);
    checkOutput("rm_relevel", levA, 2'b01);
    applyStimulus(2'b11, 2'b00);
    tick(6);
    checkOutput("rm_release", relA, 2'b01);
    tick(2);

    checkOutput("cnt_press0",   pressCnt0, 5);
    checkOutput("cnt_release0", releaseCnt0, 4);
    checkOutput("cnt_long0",    longCnt0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Multi-channel push-button event controller: synchronises, debounces and classifies up to KEY_NUM raw button inputs in the I_clk domain. Per key it produces:
- a stable level;
- one-cycle press, release and long-press pulses;
- a toggle flag with selectable trigger.

It is the parametrised successor of the single-key toggle debouncer that drives the video-source mux (test pattern vs. camera). It sits in video_top beside the reset synchroniser and feeds mode/select logic.

## Interface
- CLK_FREQ, 27_000_000: I_clk frequency in Hz.
- KEY_NUM, 1: number of independent key channels (1..16).
- DEBOUNCE_MS, 20: stable time required to accept a level change.
- LONG_MS, 500: hold time, measured from accepted press, that qualifies a long press.
- KEY_ACTIVE_LOW, 1: 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed.
- TOGGLE_SRC, 0: 0 = toggle on every accepted press; 1 = toggle on release of a short press only (no toggle if a long press fired).
- I_clk  in  1  system clock; the only clock.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_key  in  KEY_NUM  raw asynchronous button inputs.
- O_key_level  out  KEY_NUM  debounced level, 1 = pressed.
- O_press_pulse  out  KEY_NUM  one-cycle pulse on accepted press.
- O_release_pulse  out  KEY_NUM  one-cycle pulse on accepted release.
- O_long_pulse  out  KEY_NUM  one-cycle pulse when a held press reaches LONG_MS.
- O_toggle  out  KEY_NUM  toggle flag per TOGGLE_SRC.

## Operation
- Derived constants:
  - DEB_CYC = CLK_FREQ/1000*DEBOUNCE_MS.
  - LONG_CYC = CLK_FREQ/1000*LONG_MS.
  - Counter width = $clog2(LONG_CYC+1).
- Elaboration error unless DEBOUNCE_MS >= 1, LONG_CYC > DEB_CYC, and 1 <= KEY_NUM <= 16.
- Per channel:
  - Two-flop synchroniser.
  - Polarity normalisation to "pressed = 1".
  - Debounce counter and hold counter.
  - State machine with states IDLE, PRESSED, LONG_HELD.
- Debounce (all states):
  - The counter increments each cycle the synchronised level differs from O_key_level.
  - It clears to 0 in any cycle the two are equal.
  - When it reaches DEB_CYC-1 while still differing, O_key_level flips on the next edge and the counter clears.
- IDLE -> PRESSED on accepted press: O_press_pulse=1 for that cycle; hold counter cleared.
- PRESSED:
  - The hold counter increments every cycle.
  - At LONG_CYC-1 -> LONG_HELD, with O_long_pulse=1 for one cycle. Exactly one long pulse per press; no auto-repeat.
- PRESSED or LONG_HELD -> IDLE on accepted release: O_release_pulse=1 for one cycle.
- Toggle:
  - TOGGLE_SRC=0: O_toggle inverts in the cycle O_press_pulse is asserted.
  - TOGGLE_SRC=1: O_toggle inverts with O_release_pulse only when leaving PRESSED, never when leaving LONG_HELD.
- Channels are fully independent. Simultaneous events on different keys are all reported in the same cycle.
- Glitches shorter than DEB_CYC cycles produce no output change.
- The hold counter saturates in LONG_HELD; it never wraps.

## Timing
- Reset (async assert, sync release via the existing reset synchroniser):
  - All outputs 0.
  - State IDLE; counters 0.
  - Synchroniser flops at the inactive raw level (1 if KEY_ACTIVE_LOW).
- Reset mid-press:
  - Drops to the reset values with no release pulse.
  - A key still held after reset is detected as a fresh press after the normal debounce delay.
- Latency: raw change sampled at edge k → visible at sync output after edge k+1 → O_key_level and pulse registered at edge k+1+DEB_CYC. Total DEB_CYC+2 edges.
- All outputs are registered; no combinational path from I_key.
- O_long_pulse fires LONG_CYC edges after O_press_pulse.
- Pulses are exactly one I_clk cycle wide. Press and release of the same key are never in the same cycle.

## Structure
- Shared package key_event_pkg:
  - state enum (IDLE, PRESSED, LONG_HELD);
  - function ms_to_cycles(clk_freq, ms);
  - parameter legality checks.
- Sub-module key_event_ch: one channel (synchroniser, counters, FSM, toggle), instantiated KEY_NUM times with a generate loop.
- The top level only does the instantiation and bus concatenation.

## Test plan
Use CLK_FREQ=1000, DEBOUNCE_MS=4, LONG_MS=10, KEY_NUM=2, KEY_ACTIVE_LOW=1. This gives DEB_CYC=4 and LONG_CYC=10.
- Clean press:
  - Stimulus: key0 driven 0 at edge 10, held.
  - Required: O_key_level[0]=1 and O_press_pulse[0]=1 at edge 16 only; O_toggle[0]=1 (TOGGLE_SRC=0); O_long_pulse[0] at edge 26.
- Bounce rejection:
  - Stimulus: key0 low 3 cycles, high 1, low 3, then high.
  - Required: no pulse, O_key_level stays 0, debounce counter observed resetting.
- Short vs long release with TOGGLE_SRC=1:
  - Stimulus: press held 6 cycles after acceptance, then released.
  - Required: release pulse with O_toggle flipping to 1.
  - Stimulus: press held 15 cycles.
  - Required: long pulse, then a release pulse with O_toggle unchanged.
- Simultaneous keys:
  - Stimulus: key0 and key1 go low at the same edge.
  - Required: both press pulses at the same edge, 6 later; independent releases.
- Reset mid-press:
  - Stimulus: assert I_rst_n=0 in LONG_HELD while the key stays low.
  - Required: all outputs 0 immediately with no release pulse; after deassert, a press pulse 6 edges later.
- Polarity:
  - Stimulus: KEY_ACTIVE_LOW=0, raw key driven 1.
  - Required: identical press timing to the clean-press scenario.
